err_capture_ctl: RTL and testbench
==================================

Name: err_capture_ctl

Overview:
Sequences error capture for the two NSDP checker channels ahead of the AXI register reporter. Software-driven arm/clear pulses move each channel through disarmed, armed and latched states. In the latched state the first error's code, 512-bit data beat and expected frame-data word are frozen. Per-channel error counts and first-error ordering are kept, and a level interrupt is driven. Its outputs feed the reporter's status/error/error_data/expected_fdata inputs directly.

Parameters:
CNT_W, 16, width of each per-channel saturating error counter
DATA_W, 512, width of captured error data beat

Ports:
clk  input  1  system clock
resetn  input  1  reset; synchronous, active-low
arm  input  1  one-cycle pulse: arm both channels and zero all snapshots/counters
clear  input  1  one-cycle pulse: disarm both channels (snapshots and counters retained)
irq_enable  input  1  gates irq
ch0_err_valid, ch1_err_valid  input  1  checker error strobe, one cycle per error event
ch0_err_code, ch1_err_code  input  9  checker error code, valid with strobe
ch0_err_data, ch1_err_data  input  DATA_W  offending data beat, valid with strobe
ch0_exp_fdata, ch1_exp_fdata  input  32  expected frame-data word, valid with strobe
ch0_status, ch1_status  output  1  1 = channel latched an error
ch0_armed, ch1_armed  output  1  1 = channel in ARMED or LATCHED
ch0_error, ch1_error  output  9  latched error code
ch0_error_data, ch1_error_data  output  DATA_W  latched data beat
ch0_expected_fdata, ch1_expected_fdata  output  32  latched expected word
ch0_err_count, ch1_err_count  output  CNT_W  error strobes seen since arm, saturating
first_ch  output  2  0 = none, 1 = ch0 first, 2 = ch1 first, 3 = same cycle
irq  output  1  interrupt level

Behaviour:
- Reset (resetn=0 at posedge): both channels IDLE. All outputs 0: status, armed, error, error_data, expected_fdata, err_count, first_ch, irq.
- Per-channel FSM; the two channels are identical and independent except for first_ch.
  - IDLE: arm -> ARMED.
  - ARMED: err_valid -> LATCHED.
  - LATCHED: arm -> ARMED (re-arm).
  - ARMED/LATCHED: clear -> IDLE.
- Priority within a cycle: resetn > clear > arm > err_valid.
  - clear and arm in the same cycle: clear wins; channel goes to IDLE and nothing is zeroed.
- arm effect, registered at the posedge where arm=1:
  - error, error_data, expected_fdata, err_count and first_ch set to 0.
  - An err_valid in the arm cycle is ignored: not counted, not captured.
- Capture happens at the posedge where state=ARMED and err_valid=1.
  - error/error_data/expected_fdata take the inputs; status=1 visible the next cycle (1-cycle latency).
  - Later strobes in LATCHED do not alter the snapshot.
- err_count increments by 1 on each err_valid while ARMED or LATCHED, including the capturing strobe.
  - Saturates at 2^CNT_W-1; no wrap.
  - Holds its value in IDLE.
- first_ch is written only while first_ch==0.
  - Set to 1 or 2 on the first channel capture.
  - Set to 3 if both channels capture on the same posedge.
  - Cleared only by arm or reset.
- armed = (state != IDLE). status = (state == LATCHED).
- irq = irq_enable & (ch0_status | ch1_status), registered, so it lags status by 1 cycle.
  - Deasserts one cycle after clear/arm or after irq_enable drops.
- Snapshot and count registers hold their values through IDLE after clear, so software can read them post-disarm.
- Reset mid-capture (resetn=0 coincident with err_valid): reset wins, nothing captured.

Test Plan:
1. Reset, arm, then ch0_err_valid with code 9'h05, data {16{32'hDEADBEEF}}, exp 32'h1234 -> next cycle ch0_status=1, ch0_error=5, data/exp match, ch0_err_count=1, first_ch=1; a further cycle later irq=1 (irq_enable=1).
2. Armed, three more ch0 strobes with different codes -> snapshot unchanged, count=4; ch1_status stays 0.
3. Armed, ch0 and ch1 strobes on the same cycle -> both status=1, first_ch=3; a later ch1 strobe leaves first_ch=3.
4. CNT_W=4, armed, 20 strobes on ch1 -> ch1_err_count=15 and holds there.
5. Latched, arm and clear on the same cycle -> IDLE, status=0, snapshot and count retained; a subsequent strobe is ignored (count unchanged); irq falls.
6. Arm coincident with ch0_err_valid -> ARMED, count=0, status=0. Next-cycle strobe captures. Assert resetn=0 during a strobe -> all outputs 0.

Source files
------------

// File: rtl/err_capture_ctl.sv
// ---------------------------------------------------------------------------
// err_capture_ctl
//
// Sequences first-error capture for the two NSDP checker channels ahead of the
// AXI register reporter. Each channel walks IDLE -> ARMED -> LATCHED under
// software arm/clear pulses. On the first error while ARMED, the channel
// freezes the error code, the 512-bit data beat and the expected frame-data
// word. It also keeps a saturating count of error strobes, records which
// channel captured first, and drives a registered level interrupt.
//
// Handshake: there is no back-pressure. A checker strobe (chN_err_valid) is a
// single-cycle event, and its code/data/expected word are valid only in that
// same cycle. arm and clear are single-cycle software pulses. Within one cycle
// the priority is resetn > clear > arm > err_valid.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   arm, clear                     software pulses (arm zeroes, clear disarms)
//   irq_enable                     gates irq
//   chN_err_valid/code/data/exp_fdata   checker error strobe and payload
//   chN_status                     1 = channel latched an error
//   chN_armed                      1 = channel ARMED or LATCHED
//   chN_error/error_data/expected_fdata  frozen first-error snapshot
//   chN_err_count                  strobes seen since arm, saturating
//   first_ch                       0 none, 1 ch0, 2 ch1, 3 same cycle
//   irq                            interrupt level, lags status by 1 cycle
// ---------------------------------------------------------------------------
module err_capture_ctl #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              clear,
    input  logic              irq_enable,
    input  logic              ch0_err_valid,
    input  logic              ch1_err_valid,
    input  logic [8:0]        ch0_err_code,
    input  logic [8:0]        ch1_err_code,
    input  logic [DATA_W-1:0] ch0_err_data,
    input  logic [DATA_W-1:0] ch1_err_data,
    input  logic [31:0]       ch0_exp_fdata,
    input  logic [31:0]       ch1_exp_fdata,
    output logic              ch0_status,
    output logic              ch1_status,
    output logic              ch0_armed,
    output logic              ch1_armed,
    output logic [8:0]        ch0_error,
    output logic [8:0]        ch1_error,
    output logic [DATA_W-1:0] ch0_error_data,
    output logic [DATA_W-1:0] ch1_error_data,
    output logic [31:0]       ch0_expected_fdata,
    output logic [31:0]       ch1_expected_fdata,
    output logic [CNT_W-1:0]  ch0_err_count,
    output logic [CNT_W-1:0]  ch1_err_count,
    output logic [1:0]        first_ch,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LATCHED = 2'd2
    } state_t;

    // Index 0 = channel 0, index 1 = channel 1.
    state_t              r_state     [2];
    state_t              w_state_nxt [2];
    logic                w_capture   [2];
    logic                w_count     [2];

    logic                w_err_valid [2];
    logic [8:0]          w_err_code  [2];
    logic [DATA_W-1:0]   w_err_data  [2];
    logic [31:0]         w_exp_fdata [2];

    logic [8:0]          r_error     [2];
    logic [DATA_W-1:0]   r_error_data[2];
    logic [31:0]         r_exp_fdata [2];
    logic [CNT_W-1:0]    r_err_count [2];
    logic [1:0]          r_first_ch;
    logic                r_irq;

    // An arm pulse is effective only when clear is not in the same cycle.
    logic                w_arm_eff;
    logic                w_status_any;

    assign w_err_valid[0] = ch0_err_valid;
    assign w_err_valid[1] = ch1_err_valid;
    assign w_err_code[0]  = ch0_err_code;
    assign w_err_code[1]  = ch1_err_code;
    assign w_err_data[0]  = ch0_err_data;
    assign w_err_data[1]  = ch1_err_data;
    assign w_exp_fdata[0] = ch0_exp_fdata;
    assign w_exp_fdata[1] = ch1_exp_fdata;

    assign w_arm_eff    = arm & ~clear;
    assign w_status_any = (r_state[0] == ST_LATCHED) | (r_state[1] == ST_LATCHED);

    // Next-state and per-channel capture/count strobes. A strobe coincident
    // with arm or clear is dropped entirely.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_state_nxt[c] = r_state[c];
            w_capture[c]   = 1'b0;
            w_count[c]     = 1'b0;
            if (clear) begin
                w_state_nxt[c] = ST_IDLE;
            end else if (arm) begin
                w_state_nxt[c] = ST_ARMED;
            end else begin
                if (r_state[c] == ST_ARMED && w_err_valid[c]) begin
                    w_state_nxt[c] = ST_LATCHED;
                    w_capture[c]   = 1'b1;
                end
                if (r_state[c] != ST_IDLE && w_err_valid[c]) begin
                    w_count[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int c = 0; c < 2; c++) begin
                r_state[c]      <= ST_IDLE;
                r_error[c]      <= '0;
                r_error_data[c] <= '0;
                r_exp_fdata[c]  <= '0;
                r_err_count[c]  <= '0;
            end
            r_first_ch <= 2'd0;
            r_irq      <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= w_state_nxt[c];
                if (w_arm_eff) begin
                    r_error[c]      <= '0;
                    r_error_data[c] <= '0;
                    r_exp_fdata[c]  <= '0;
                    r_err_count[c]  <= '0;
                end else begin
                    if (w_capture[c]) begin
                        r_error[c]      <= w_err_code[c];
                        r_error_data[c] <= w_err_data[c];
                        r_exp_fdata[c]  <= w_exp_fdata[c];
                    end
                    // Saturate at all-ones rather than wrap.
                    if (w_count[c] && (r_err_count[c] != {CNT_W{1'b1}})) begin
                        r_err_count[c] <= r_err_count[c] + CNT_W'(1);
                    end
                end
            end

            // First-capture ordering is sticky until the next arm.
            if (w_arm_eff) begin
                r_first_ch <= 2'd0;
            end else if (r_first_ch == 2'd0) begin
                r_first_ch <= {w_capture[1], w_capture[0]};
            end

            r_irq <= irq_enable & w_status_any;
        end
    end

    assign ch0_status         = (r_state[0] == ST_LATCHED);
    assign ch1_status         = (r_state[1] == ST_LATCHED);
    assign ch0_armed          = (r_state[0] != ST_IDLE);
    assign ch1_armed          = (r_state[1] != ST_IDLE);
    assign ch0_error          = r_error[0];
    assign ch1_error          = r_error[1];
    assign ch0_error_data     = r_error_data[0];
    assign ch1_error_data     = r_error_data[1];
    assign ch0_expected_fdata = r_exp_fdata[0];
    assign ch1_expected_fdata = r_exp_fdata[1];
    assign ch0_err_count      = r_err_count[0];
    assign ch1_err_count      = r_err_count[1];
    assign first_ch           = r_first_ch;
    assign irq                = r_irq;

endmodule

// File: tb/tb_err_capture_ctl.sv
// ---------------------------------------------------------------------------
// tb_err_capture_ctl
//
// Directed bench for err_capture_ctl, built with CNT_W=4 so that counter
// saturation is reachable. A table of {inputs, expected outputs} rows is
// applied one clock per row. Hand-written sequences cover saturation and
// reset coincident with a strobe.
// ---------------------------------------------------------------------------
module tb_err_capture_ctl;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn, arm, clear, irq_enable;
  logic              ch0_err_valid, ch1_err_valid;
  logic [8:0]        ch0_err_code, ch1_err_code;
  logic [DATA_W-1:0] ch0_err_data, ch1_err_data;
  logic [31:0]       ch0_exp_fdata, ch1_exp_fdata;
  logic              ch0_status, ch1_status, ch0_armed, ch1_armed;
  logic [8:0]        ch0_error, ch1_error;
  logic [DATA_W-1:0] ch0_error_data, ch1_error_data;
  logic [31:0]       ch0_expected_fdata, ch1_expected_fdata;
  logic [CNT_W-1:0]  ch0_err_count, ch1_err_count;
  logic [1:0]        first_ch;
  logic              irq;

  err_capture_ctl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .clear(clear), .irq_enable(irq_enable),
    .ch0_err_valid(ch0_err_valid), .ch1_err_valid(ch1_err_valid),
    .ch0_err_code(ch0_err_code), .ch1_err_code(ch1_err_code),
    .ch0_err_data(ch0_err_data), .ch1_err_data(ch1_err_data),
    .ch0_exp_fdata(ch0_exp_fdata), .ch1_exp_fdata(ch1_exp_fdata),
    .ch0_status(ch0_status), .ch1_status(ch1_status),
    .ch0_armed(ch0_armed), .ch1_armed(ch1_armed),
    .ch0_error(ch0_error), .ch1_error(ch1_error),
    .ch0_error_data(ch0_error_data), .ch1_error_data(ch1_error_data),
    .ch0_expected_fdata(ch0_expected_fdata), .ch1_expected_fdata(ch1_expected_fdata),
    .ch0_err_count(ch0_err_count), .ch1_err_count(ch1_err_count),
    .first_ch(first_ch), .irq(irq)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Payload derived from the code, so code 5 gives {16{DEADBEEF}} / 32'h1234.
  function automatic logic [DATA_W-1:0] data_for(input logic [8:0] code);
    logic [31:0] w;
    w = 32'hDEADBEEF + 32'(code) - 32'd5;
    return {16{w}};
  endfunction

  function automatic logic [31:0] fdata_for(input logic [8:0] code);
    return 32'h1234 + 32'(code) - 32'd5;
  endfunction

  // A code of 0 means "snapshot is zeroed" in the expectation tables.
  function automatic logic [DATA_W-1:0] exp_data(input logic [8:0] code);
    return (code == 9'd0) ? '0 : data_for(code);
  endfunction

  function automatic logic [31:0] exp_fd(input logic [8:0] code);
    return (code == 9'd0) ? 32'd0 : fdata_for(code);
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    arm = 1'b0; clear = 1'b0;
    ch0_err_valid = 1'b0; ch1_err_valid = 1'b0;
    ch0_err_code = '0; ch1_err_code = '0;
    ch0_err_data = '0; ch1_err_data = '0;
    ch0_exp_fdata = '0; ch1_exp_fdata = '0;
  endtask

  task automatic drive_ch(input int ch, input logic v, input logic [8:0] code);
    if (ch == 0) begin
      ch0_err_valid = v; ch0_err_code = code;
      ch0_err_data = data_for(code); ch0_exp_fdata = fdata_for(code);
    end else begin
      ch1_err_valid = v; ch1_err_code = code;
      ch1_err_data = data_for(code); ch1_exp_fdata = fdata_for(code);
    end
  endtask

  // Advance one active edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic s0, input logic s1, input logic a0, input logic a1,
                         input logic [8:0] e0, input logic [8:0] e1,
                         input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                         input logic [1:0] f, input logic q);
    chk({tag, ".ch0_status"}, DATA_W'(ch0_status), DATA_W'(s0));
    chk({tag, ".ch1_status"}, DATA_W'(ch1_status), DATA_W'(s1));
    chk({tag, ".ch0_armed"}, DATA_W'(ch0_armed), DATA_W'(a0));
    chk({tag, ".ch1_armed"}, DATA_W'(ch1_armed), DATA_W'(a1));
    chk({tag, ".ch0_error"}, DATA_W'(ch0_error), DATA_W'(e0));
    chk({tag, ".ch1_error"}, DATA_W'(ch1_error), DATA_W'(e1));
    chk({tag, ".ch0_error_data"}, ch0_error_data, exp_data(e0));
    chk({tag, ".ch1_error_data"}, ch1_error_data, exp_data(e1));
    chk({tag, ".ch0_exp_fdata"}, DATA_W'(ch0_expected_fdata), DATA_W'(exp_fd(e0)));
    chk({tag, ".ch1_exp_fdata"}, DATA_W'(ch1_expected_fdata), DATA_W'(exp_fd(e1)));
    chk({tag, ".ch0_err_count"}, DATA_W'(ch0_err_count), DATA_W'(c0));
    chk({tag, ".ch1_err_count"}, DATA_W'(ch1_err_count), DATA_W'(c1));
    chk({tag, ".first_ch"}, DATA_W'(first_ch), DATA_W'(f));
    chk({tag, ".irq"}, DATA_W'(irq), DATA_W'(q));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       arm, clear, irq_en, v0, v1;
    logic [8:0] code0, code1;
    logic       s0, s1, a0, a1;
    logic [8:0] e0, e1;
    logic [CNT_W-1:0] c0, c1;
    logic [1:0] f;
    logic       q;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic am, input logic cl, input logic en,
                              input logic v0, input logic [8:0] k0,
                              input logic v1, input logic [8:0] k1,
                              input logic s0, input logic s1, input logic a0, input logic a1,
                              input logic [8:0] e0, input logic [8:0] e1,
                              input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                              input logic [1:0] f, input logic q);
    vec_t r;
    r.arm = am; r.clear = cl; r.irq_en = en; r.v0 = v0; r.v1 = v1;
    r.code0 = k0; r.code1 = k1; r.s0 = s0; r.s1 = s1; r.a0 = a0; r.a1 = a1;
    r.e0 = e0; r.e1 = e1; r.c0 = c0; r.c1 = c1; r.f = f; r.q = q;
    return r;
  endfunction

  initial begin
    //            arm clr en  v0 code0   v1 code1   s0 s1 a0 a1 e0      e1      c0 c1 f  irq
    vecs[0]  = mk(1, 0, 1,  0, 9'h00,  0, 9'h00,  0, 0, 1, 1, 9'h00, 9'h00, 0, 0, 0, 0); // arm
    vecs[1]  = mk(0, 0, 1,  1, 9'h05,  0, 9'h00,  1, 0, 1, 1, 9'h05, 9'h00, 1, 0, 1, 0); // ch0 capture
    vecs[2]  = mk(0, 0, 1,  0, 9'h00,  0, 9'h00,  1, 0, 1, 1, 9'h05, 9'h00, 1, 0, 1, 1); // irq rises
    vecs[3]  = mk(0, 0, 1,  1, 9'h06,  0, 9'h00,  1, 0, 1, 1, 9'h05, 9'h00, 2, 0, 1, 1);
    vecs[4]  = mk(0, 0, 1,  1, 9'h07,  0, 9'h00,  1, 0, 1, 1, 9'h05, 9'h00, 3, 0, 1, 1);
    vecs[5]  = mk(0, 0, 1,  1, 9'h08,  0, 9'h00,  1, 0, 1, 1, 9'h05, 9'h00, 4, 0, 1, 1); // snapshot frozen
    vecs[6]  = mk(1, 0, 1,  0, 9'h00,  0, 9'h00,  0, 0, 1, 1, 9'h00, 9'h00, 0, 0, 0, 1); // re-arm, irq lags
    vecs[7]  = mk(0, 0, 1,  1, 9'h10,  1, 9'h20,  1, 1, 1, 1, 9'h10, 9'h20, 1, 1, 3, 0); // same-cycle capture
    vecs[8]  = mk(0, 0, 1,  0, 9'h00,  1, 9'h21,  1, 1, 1, 1, 9'h10, 9'h20, 1, 2, 3, 1); // first_ch sticky
    vecs[9]  = mk(1, 1, 1,  0, 9'h00,  0, 9'h00,  0, 0, 0, 0, 9'h10, 9'h20, 1, 2, 3, 1); // clear beats arm
    vecs[10] = mk(0, 0, 1,  1, 9'h30,  1, 9'h30,  0, 0, 0, 0, 9'h10, 9'h20, 1, 2, 3, 0); // IDLE ignores, irq falls
    vecs[11] = mk(1, 0, 1,  1, 9'h40,  0, 9'h00,  0, 0, 1, 1, 9'h00, 9'h00, 0, 0, 0, 0); // strobe in arm cycle dropped
    vecs[12] = mk(0, 0, 1,  1, 9'h41,  0, 9'h00,  1, 0, 1, 1, 9'h41, 9'h00, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 0,  0, 9'h00,  0, 9'h00,  1, 0, 1, 1, 9'h41, 9'h00, 1, 0, 1, 0); // irq gated
    vecs[14] = mk(0, 0, 1,  0, 9'h00,  0, 9'h00,  1, 0, 1, 1, 9'h41, 9'h00, 1, 0, 1, 1);
    vecs[15] = mk(0, 0, 0,  0, 9'h00,  0, 9'h00,  1, 0, 1, 1, 9'h41, 9'h00, 1, 0, 1, 0); // enable drop
  end

  // ---------------- main test ----------------
  initial begin
    drive_idle();
    irq_enable = 1'b1;
    resetn = 1'b0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 9'h00, 9'h00, 0, 0, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive_idle();
      arm = vecs[i].arm;
      clear = vecs[i].clear;
      irq_enable = vecs[i].irq_en;
      drive_ch(0, vecs[i].v0, vecs[i].code0);
      drive_ch(1, vecs[i].v1, vecs[i].code1);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].a0, vecs[i].a1,
              vecs[i].e0, vecs[i].e1, vecs[i].c0, vecs[i].c1, vecs[i].f, vecs[i].q);
    end

    // Counter saturation on ch1 (CNT_W=4 -> max 15).
    drive_idle();
    irq_enable = 1'b1;
    arm = 1'b1;
    step();
    drive_idle();
    for (int i = 0; i < 20; i++) begin
      drive_ch(1, 1'b1, 9'(9'h50 + i));
      step();
      chk($sformatf("sat.cnt%0d", i), DATA_W'(ch1_err_count), DATA_W'((i + 1 > 15) ? 15 : i + 1));
    end
    drive_idle();
    step(); step();
    chk("sat.hold", DATA_W'(ch1_err_count), DATA_W'(15));
    chk("sat.code", DATA_W'(ch1_error), DATA_W'(9'h50));
    chk("sat.data", ch1_error_data, data_for(9'h50));
    chk("sat.ch0_cnt", DATA_W'(ch0_err_count), DATA_W'(0));
    chk("sat.first", DATA_W'(first_ch), DATA_W'(2));

    // Reset coincident with a strobe: nothing captured, all zero.
    drive_ch(0, 1'b1, 9'h60);
    resetn = 1'b0;
    step();
    chk_all("rst_strobe", 0, 0, 0, 0, 9'h00, 9'h00, 0, 0, 0, 0);
    resetn = 1'b1;
    drive_ch(0, 1'b1, 9'h61);
    step();
    chk_all("post_rst_idle", 0, 0, 0, 0, 9'h00, 9'h00, 0, 0, 0, 0);
    drive_idle();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
